// File: rtl/module_spi_transaction_ctrl_if.sv
// Bundle of the controller's command, register-bank and SPI pins.
// master = transaction controller side, slave = bank/client/SPI device side.
interface module_spi_transaction_ctrl_if #(
    parameter int N          = 2,
    parameter int DATA_WIDTH = 32
);
    logic                  send_i;
    logic [N-1:0]          n_tx_end_i;
    logic                  all_ones_i;
    logic                  all_zeros_i;
    logic [DATA_WIDTH-1:0] data_i;
    logic [N-1:0]          addr_o;
    logic [DATA_WIDTH-1:0] data_o;
    logic                  wr_o;
    logic                  hold_ctrl_o;
    logic                  busy_o;
    logic                  done_o;
    logic [N-1:0]          n_rx_end_o;
    logic                  sck_o;
    logic                  mosi_o;
    logic                  miso_i;
    logic                  cs_o;

    modport master (
        input  send_i, n_tx_end_i, all_ones_i, all_zeros_i, data_i, miso_i,
        output addr_o, data_o, wr_o, hold_ctrl_o, busy_o, done_o, n_rx_end_o,
               sck_o, mosi_o, cs_o
    );

    modport slave (
        output send_i, n_tx_end_i, all_ones_i, all_zeros_i, data_i, miso_i,
        input  addr_o, data_o, wr_o, hold_ctrl_o, busy_o, done_o, n_rx_end_o,
               sck_o, mosi_o, cs_o
    );
endinterface

// File: rtl/module_spi_transaction_ctrl.sv
// SPI mode-0 master that streams bank words 0..n_tx_end out on MOSI and writes
// each received byte back to the same bank address, holding client writes off.
module module_spi_transaction_ctrl #(
    parameter int N          = 2,
    parameter int DATA_WIDTH = 32,
    parameter int DIV        = 5
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    module_spi_transaction_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SHIFT = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int            CW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

    state_t                state_q, state_d;
    logic [N-1:0]          idx_q, idx_d, end_q, end_d;
    logic [7:0]            tx_q, tx_d, rx_q, rx_d, tx_sel_s;
    logic [CW-1:0]         div_q, div_d;
    logic [3:0]            edge_q, edge_d;
    logic [N-1:0]          addr_q, addr_d, n_rx_end_q, n_rx_end_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  wr_q, wr_d, hold_q, hold_d, busy_q, busy_d, done_q, done_d;
    logic                  sck_q, sck_d, mosi_q, mosi_d, cs_q, cs_d;

    // TX byte source for the word currently addressed; all-ones wins over all-zeros.
    always_comb begin
        if (bus.all_ones_i) begin
            tx_sel_s = 8'hFF;
        end else if (bus.all_zeros_i) begin
            tx_sel_s = 8'h00;
        end else begin
            tx_sel_s = bus.data_i[7:0];
        end
    end

    // Next-state and next-output logic of the transaction FSM.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        end_d      = end_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        div_d      = div_q;
        edge_d     = edge_q;
        addr_d     = addr_q;
        data_d     = data_q;
        wr_d       = 1'b0;
        hold_d     = hold_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        n_rx_end_d = n_rx_end_q;
        sck_d      = sck_q;
        mosi_d     = mosi_q;
        cs_d       = cs_q;
        case (state_q)
            IDLE: begin
                if (bus.send_i) begin
                    state_d = LOAD;
                    end_d   = bus.n_tx_end_i;
                    idx_d   = '0;
                    addr_d  = '0;
                    busy_d  = 1'b1;
                    hold_d  = 1'b1;
                    cs_d    = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                tx_d    = tx_sel_s;
                mosi_d  = tx_sel_s[7];
                div_d   = '0;
                edge_d  = 4'd0;
                sck_d   = 1'b0;
                state_d = SHIFT;
            end
            SHIFT: begin
                if (div_q == DIV_LAST) begin
                    div_d  = '0;
                    sck_d  = ~sck_q;
                    edge_d = edge_q + 4'd1;
                    if (!sck_q) begin
                        rx_d = {rx_q[6:0], bus.miso_i};
                    end else if (edge_q == 4'd15) begin
                        // Eighth falling edge: byte complete, present it for write-back.
                        state_d = WRITE;
                        wr_d    = 1'b1;
                        data_d  = DATA_WIDTH'(rx_q);
                    end else begin
                        tx_d   = {tx_q[6:0], 1'b0};
                        mosi_d = tx_q[6];
                    end
                end else begin
                    div_d = div_q + CW'(1);
                end
            end
            WRITE: begin
                if (idx_q == end_q) begin
                    state_d = DONE;
                    cs_d    = 1'b1;
                end else begin
                    idx_d   = idx_q + N'(1);
                    addr_d  = idx_q + N'(1);
                    state_d = LOAD;
                end
            end
            DONE: begin
                state_d    = IDLE;
                done_d     = 1'b1;
                n_rx_end_d = end_q;
                busy_d     = 1'b0;
                hold_d     = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            end_q      <= '0;
            tx_q       <= 8'h00;
            rx_q       <= 8'h00;
            div_q      <= '0;
            edge_q     <= 4'd0;
            addr_q     <= '0;
            data_q     <= '0;
            wr_q       <= 1'b0;
            hold_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            n_rx_end_q <= '0;
            sck_q      <= 1'b0;
            mosi_q     <= 1'b0;
            cs_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            end_q      <= end_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            div_q      <= div_d;
            edge_q     <= edge_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            wr_q       <= wr_d;
            hold_q     <= hold_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            n_rx_end_q <= n_rx_end_d;
            sck_q      <= sck_d;
            mosi_q     <= mosi_d;
            cs_q       <= cs_d;
        end
    end

    assign bus.addr_o      = addr_q;
    assign bus.data_o      = data_q;
    assign bus.wr_o        = wr_q;
    assign bus.hold_ctrl_o = hold_q;
    assign bus.busy_o      = busy_q;
    assign bus.done_o      = done_q;
    assign bus.n_rx_end_o  = n_rx_end_q;
    assign bus.sck_o       = sck_q;
    assign bus.mosi_o      = mosi_q;
    assign bus.cs_o        = cs_q;
endmodule

// File: tb/tb_module_spi_transaction_ctrl.sv
// Bench for module_spi_transaction_ctrl: behavioural register bank with a held
// client port, SPI slave (replay or loopback), and a write/MOSI scoreboard.
`timescale 1ns/1ps
module tb_module_spi_transaction_ctrl;
    localparam int N   = 2;
    localparam int DW  = 32;
    localparam int DIV = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #50 clk = ~clk;

    module_spi_transaction_ctrl_if #(.N(N), .DATA_WIDTH(DW)) bus ();

    module_spi_transaction_ctrl #(.N(N), .DATA_WIDTH(DW), .DIV(DIV)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus.master)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Register bank: controller write port has priority, client port is held off.
    logic [DW-1:0] bank [4];
    logic          c_wr = 1'b0;
    logic [N-1:0]  c_addr = '0;
    logic [DW-1:0] c_data = '0;
    assign bus.data_i = bank[bus.addr_o];
    always @(posedge clk) begin
        if (bus.wr_o) bank[bus.addr_o] <= bus.data_o;
        else if (c_wr && !bus.hold_ctrl_o) bank[c_addr] <= c_data;
    end

    // SPI slave: replays miso_byte MSB first, or loops MOSI back.
    logic       loopback = 1'b0;
    logic       miso_replay = 1'b0;
    logic [7:0] miso_byte = 8'h00;
    assign bus.miso_i = loopback ? bus.mosi_o : miso_replay;

    typedef struct packed {
        logic [N-1:0]  addr;
        logic [DW-1:0] data;
        logic [7:0]    tx;
    } exp_wr_t;
    exp_wr_t sb_q[$];

    int         rise_cnt = 0;
    int         done_cnt = 0;
    logic       sck_prev = 1'b0;
    logic [7:0] mosi_byte = 8'h00;

    // Monitor: collect MOSI on SCK rises, score each bank write.
    always @(negedge clk) begin : mon
        exp_wr_t e;
        if (bus.cs_o) rise_cnt = 0;
        else if (bus.sck_o && !sck_prev) begin
            mosi_byte = {mosi_byte[6:0], bus.mosi_o};
            rise_cnt++;
        end
        if (bus.wr_o) begin
            chk("wr_expected", 64'(sb_q.size() > 0), 64'd1);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("wr_addr", 64'(bus.addr_o), 64'(e.addr));
                chk("wr_data", 64'(bus.data_o), 64'(e.data));
                chk("mosi_byte", 64'(mosi_byte), 64'(e.tx));
                chk("rises_per_word", 64'(rise_cnt), 64'd8);
            end
            rise_cnt = 0;
        end
        if (bus.done_o) done_cnt++;
        sck_prev = bus.sck_o;
        miso_replay = (rise_cnt < 8) ? miso_byte[3'(7 - rise_cnt)] : 1'b0;
    end

    typedef struct {
        logic [N-1:0]        n_end;
        logic                ones;
        logic                zeros;
        logic                loop;
        logic [7:0]          miso;
        logic [3:0][DW-1:0]  words;
        int                  exp_lat;
        int                  exp_cs;
    } vec_t;
    vec_t vecs [5];

    task automatic bank_write(input logic [N-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        c_wr = 1'b1; c_addr = a; c_data = d;
        @(negedge clk);
        c_wr = 1'b0;
    endtask

    task automatic prep_vec(input int i);
        logic [7:0] tx, rx;
        for (int a = 0; a < 4; a++) bank_write(N'(a), vecs[i].words[a]);
        loopback  = vecs[i].loop;
        miso_byte = vecs[i].miso;
        for (int w = 0; w <= int'(vecs[i].n_end); w++) begin
            tx = vecs[i].ones ? 8'hFF : (vecs[i].zeros ? 8'h00 : vecs[i].words[w][7:0]);
            rx = vecs[i].loop ? tx : vecs[i].miso;
            sb_q.push_back('{addr: N'(w), data: DW'(rx), tx: tx});
        end
    endtask

    task automatic start_send(input logic [N-1:0] e, input logic o, input logic z);
        @(negedge clk);
        bus.n_tx_end_i = e; bus.all_ones_i = o; bus.all_zeros_i = z; bus.send_i = 1'b1;
        @(posedge clk); #1;
        bus.send_i = 1'b0;
    endtask

    // Called #1 after the edge that sampled send; counts cycles up to done_o.
    task automatic wait_done(input int exp_lat, input int exp_cs, input logic [N-1:0] e);
        int lat = -1;
        int cs_low = 0;
        logic hold_ok = 1'b1;
        if (!bus.cs_o) cs_low++;
        if (!bus.hold_ctrl_o || !bus.busy_o) hold_ok = 1'b0;
        for (int k = 1; k <= 400; k++) begin
            @(posedge clk); #1;
            if (bus.done_o) begin lat = k; break; end
            if (!bus.cs_o) cs_low++;
            if (!bus.hold_ctrl_o || !bus.busy_o) hold_ok = 1'b0;
        end
        chk("done_latency", 64'(lat), 64'(exp_lat));
        chk("cs_low_cycles", 64'(cs_low), 64'(exp_cs));
        chk("hold_busy_during_txn", 64'(hold_ok), 64'd1);
        chk("n_rx_end", 64'(bus.n_rx_end_o), 64'(e));
        chk("busy_at_done", 64'(bus.busy_o), 64'd0);
        chk("hold_at_done", 64'(bus.hold_ctrl_o), 64'd0);
        chk("cs_at_done", 64'(bus.cs_o), 64'd1);
        @(posedge clk); #1;
        chk("done_one_cycle", 64'(bus.done_o), 64'd0);
    endtask

    initial begin : watchdog
        #(100 * 60000);
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin : main
        int d0;
        logic found;
        vecs[0] = '{2'd0, 1'b0, 1'b0, 1'b0, 8'h3C, {32'h0, 32'h0, 32'h0, 32'h0000_00A5}, 35, 34};
        vecs[1] = '{2'd3, 1'b0, 1'b0, 1'b1, 8'h00, {32'h44, 32'h33, 32'h22, 32'h11}, 137, 136};
        vecs[2] = '{2'd0, 1'b1, 1'b1, 1'b0, 8'h5A, {32'h0, 32'h0, 32'h0, 32'h0000_0000}, 35, 34};
        vecs[3] = '{2'd0, 1'b0, 1'b1, 1'b0, 8'hC3, {32'h0, 32'h0, 32'h0, 32'h0000_00FF}, 35, 34};
        vecs[4] = '{2'd1, 1'b0, 1'b0, 1'b0, 8'h7E, {32'h0, 32'h0, 32'h0000_0001, 32'h1234_5680}, 69, 68};

        rst_n = 1'b0;
        bus.send_i = 1'b0; bus.n_tx_end_i = '0; bus.all_ones_i = 1'b0; bus.all_zeros_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_addr", 64'(bus.addr_o), 64'd0);
        chk("rst_data", 64'(bus.data_o), 64'd0);
        chk("rst_wr", 64'(bus.wr_o), 64'd0);
        chk("rst_hold", 64'(bus.hold_ctrl_o), 64'd0);
        chk("rst_busy", 64'(bus.busy_o), 64'd0);
        chk("rst_done", 64'(bus.done_o), 64'd0);
        chk("rst_n_rx_end", 64'(bus.n_rx_end_o), 64'd0);
        chk("rst_sck", 64'(bus.sck_o), 64'd0);
        chk("rst_mosi", 64'(bus.mosi_o), 64'd0);
        chk("rst_cs", 64'(bus.cs_o), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            prep_vec(i);
            start_send(vecs[i].n_end, vecs[i].ones, vecs[i].zeros);
            wait_done(vecs[i].exp_lat, vecs[i].exp_cs, vecs[i].n_end);
            chk("sb_drained", 64'(sb_q.size()), 64'd0);
        end
        chk("bank_loopback_w3", 64'(bank[3]), 64'h0);

        // send pulsed during SHIFT of a 2-word transfer must be ignored
        prep_vec(4);
        d0 = done_cnt;
        start_send(2'd1, 1'b0, 1'b0);
        fork
            wait_done(69, 68, 2'd1);
            begin
                repeat (10) @(negedge clk);
                bus.send_i = 1'b1;
                @(negedge clk);
                bus.send_i = 1'b0;
            end
        join
        repeat (40) @(negedge clk);
        chk("busy_ignore_done_count", 64'(done_cnt - d0), 64'd1);
        chk("busy_ignore_idle", 64'(bus.busy_o), 64'd0);
        chk("busy_ignore_sb", 64'(sb_q.size()), 64'd0);

        // reset after the third SCK rise: abort with no write
        loopback = 1'b0; miso_byte = 8'hA5;
        d0 = done_cnt;
        start_send(2'd1, 1'b0, 1'b0);
        found = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (rise_cnt == 3) begin found = 1'b1; break; end
        end
        chk("third_rise_seen", 64'(found), 64'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midrst_cs", 64'(bus.cs_o), 64'd1);
        chk("midrst_sck", 64'(bus.sck_o), 64'd0);
        chk("midrst_busy", 64'(bus.busy_o), 64'd0);
        chk("midrst_hold", 64'(bus.hold_ctrl_o), 64'd0);
        chk("midrst_wr", 64'(bus.wr_o), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("midrst_no_done", 64'(done_cnt - d0), 64'd0);
        prep_vec(0);
        start_send(vecs[0].n_end, 1'b0, 1'b0);
        wait_done(35, 34, 2'd0);
        chk("post_rst_sb", 64'(sb_q.size()), 64'd0);

        // client write blocked while held, accepted afterwards
        prep_vec(1);
        void'(sb_q.pop_back()); void'(sb_q.pop_back()); void'(sb_q.pop_back());
        loopback = 1'b0; miso_byte = 8'h96;
        sb_q[0].data = DW'(8'h96);
        start_send(2'd0, 1'b0, 1'b0);
        fork
            wait_done(35, 34, 2'd0);
            begin
                repeat (5) @(negedge clk);
                bank_write(2'd3, 32'hDEAD_BEEF);
            end
        join
        chk("hold_blocks_client", 64'(bank[3]), 64'h44);
        chk("txn_wrote_bank0", 64'(bank[0]), 64'h96);
        bank_write(2'd3, 32'hDEAD_BEEF);
        chk("client_after_done", 64'(bank[3]), 64'hDEAD_BEEF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
